// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock divider / period meter pair.
package clk_meas_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam int CNT_W_DEF    = 32;
  localparam int AVG_LOG2_DEF = 2;
  localparam int TIMEOUT_DEF  = 50_000_000;

  // Index of the last period in an averaging window (window length minus one).
  function automatic int win_last(input int avg_log2);
    return int'((32'd1 << avg_log2) - 32'd1);
  endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// Measurement bus of the period meter: stimulus in, averaged result and status out.
interface clk_period_meter_if import clk_meas_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             sig_in;
  logic             en;
  logic [CNT_W-1:0] period_avg;
  logic             period_valid;
  logic             no_signal;
  logic             busy;

  modport master (
    output sig_in, en,
    input  period_avg, period_valid, no_signal, busy
  );

  modport slave (
    input  sig_in, en,
    output period_avg, period_valid, no_signal, busy
  );

endinterface

// File: rtl/sig_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus rising-edge detect.
module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchroniser chain with one extra delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of sig_in in clk cycles, averaged over 2^AVG_LOG2 periods,
// and flags loss of signal after TIMEOUT_CYC cycles without a rising edge.
module clk_period_meter import clk_meas_pkg::*; #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int AVG_LOG2    = AVG_LOG2_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  clk_period_meter_if.slave   bus
);

  localparam int SUM_W  = CNT_W + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;
  localparam logic [NPER_W-1:0] NPER_LAST   = NPER_W'(win_last(AVG_LOG2));
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [SUM_W-1:0]   sum_r;
  logic [NPER_W-1:0]  nper_r;
  logic [CNT_W-1:0]   period_avg_r;
  logic               period_valid_r;
  logic               no_signal_r;
  logic               busy_r;
  logic               rise_s;
  logic [SUM_W-1:0]   sum_next_s;
  logic [CNT_W-1:0]   avg_s;

  sig_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.sig_in),
    .rise     (rise_s)
  );

  // Accumulator including the period that ends on this rise, and its truncated mean.
  always_comb begin
    sum_next_s = sum_r + SUM_W'(cnt_r);
    avg_s      = CNT_W'(sum_next_s >> AVG_LOG2);
  end

  // Measurement FSM: arm on first rise, count cycles between rises, publish each full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      sum_r          <= '0;
      nper_r         <= '0;
      period_avg_r   <= '0;
      period_valid_r <= 1'b0;
      no_signal_r    <= 1'b1;
      busy_r         <= 1'b0;
    end else if (!bus.en) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      sum_r          <= '0;
      nper_r         <= '0;
      period_valid_r <= 1'b0;
      no_signal_r    <= 1'b1;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          period_valid_r <= 1'b0;
          sum_r          <= '0;
          nper_r         <= '0;
          if (rise_s) begin
            state_r     <= MEAS;
            cnt_r       <= CNT_W'(1'b1);
            no_signal_r <= 1'b0;
            busy_r      <= 1'b1;
          end else begin
            cnt_r <= '0;
          end
        end
        MEAS: begin
          if (rise_s) begin
            // The rise that closes one period also opens the next one.
            cnt_r <= CNT_W'(1'b1);
            if (nper_r == NPER_LAST) begin
              period_avg_r   <= avg_s;
              period_valid_r <= 1'b1;
              sum_r          <= '0;
              nper_r         <= '0;
            end else begin
              period_valid_r <= 1'b0;
              sum_r          <= sum_next_s;
              nper_r         <= nper_r + NPER_W'(1'b1);
            end
          end else if (cnt_r == TIMEOUT_VAL) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            sum_r          <= '0;
            nper_r         <= '0;
            period_valid_r <= 1'b0;
            no_signal_r    <= 1'b1;
            busy_r         <= 1'b0;
          end else begin
            cnt_r          <= cnt_r + CNT_W'(1'b1);
            period_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          cnt_r          <= '0;
          sum_r          <= '0;
          nper_r         <= '0;
          period_valid_r <= 1'b0;
          no_signal_r    <= 1'b1;
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.period_avg   = period_avg_r;
  assign bus.period_valid = period_valid_r;
  assign bus.no_signal    = no_signal_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: averaged (AVG_LOG2=2) and per-period (AVG_LOG2=0) instances.
module tb_clk_period_meter;
  import clk_meas_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sig;
  logic en;
  logic [31:0] acc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] a_log [64];
  int          a_cyc [64];
  int          a_n = 0;
  logic [31:0] b_log [64];
  int          b_n = 0;
  int          exp_b [9] = '{100, 99, 101, 98, 102, 99, 101, 98, 102};

  clk_period_meter_if #(.CNT_W(32)) ifa ();
  clk_period_meter_if #(.CNT_W(32)) ifb ();

  assign ifa.sig_in = sig;
  assign ifa.en     = en;
  assign ifb.sig_in = sig;
  assign ifb.en     = en;

  clk_period_meter #(.CNT_W(32), .AVG_LOG2(2), .TIMEOUT_CYC(1000)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa)
  );

  clk_period_meter #(.CNT_W(32), .AVG_LOG2(0), .TIMEOUT_CYC(1000)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge and log every valid result of both DUTs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ifa.period_valid) begin
      if (a_n < 64) begin
        a_log[a_n] = ifa.period_avg;
        a_cyc[a_n] = cyc;
      end
      a_n++;
    end
    if (ifb.period_valid) begin
      if (b_n < 64) b_log[b_n] = ifb.period_avg;
      b_n++;
    end
  endtask

  task automatic run(input int n, input logic level);
    sig = level;
    repeat (n) tick();
  endtask

  task automatic wave(input int p);
    run(p / 2, 1'b1);
    run(p - p / 2, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sig   = 1'b0;
    acc   = 32'd0;
    run(3, 1'b0);
    chk("reset_avg", ifa.period_avg, 32'd0);
    chk("reset_valid", {31'd0, ifa.period_valid}, 32'd0);
    chk("reset_nosig", {31'd0, ifa.no_signal}, 32'd1);
    chk("reset_busy", {31'd0, ifa.busy}, 32'd0);

    rst_n = 1'b1;
    en    = 1'b1;
    run(20, 1'b0);
    chk("idle_nosig", {31'd0, ifa.no_signal}, 32'd1);
    chk("idle_busy", {31'd0, ifa.busy}, 32'd0);

    // Steady 100-cycle square wave: arm + one full window.
    repeat (8) wave(100);
    chk("sq_count", a_n, 32'd1);
    chk("sq_avg0", a_log[0], 32'd100);
    chk("sq_nosig", {31'd0, ifa.no_signal}, 32'd0);
    chk("sq_busy", {31'd0, ifa.busy}, 32'd1);

    // Jittered periods; per-period DUT reports each one.
    b_n = 0;
    repeat (2) begin
      wave(99); wave(101); wave(98); wave(102);
    end
    wave(100);
    chk("jit_count", a_n, 32'd4);
    chk("jit_avg1", a_log[1], 32'd100);
    chk("jit_avg2", a_log[2], 32'd100);
    chk("jit_avg3", a_log[3], 32'd100);
    chk("jit_space1", a_cyc[1] - a_cyc[0], 32'd400);
    chk("jit_space2", a_cyc[2] - a_cyc[1], 32'd400);
    chk("b_count", b_n, 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("b_per%0d", i), b_log[i], exp_b[i]);

    // Signal stops: timeout 1000 cycles after the last sampled rise.
    run(902, 1'b0);
    chk("to_before", {31'd0, ifa.no_signal}, 32'd0);
    run(1, 1'b0);
    chk("to_at", {31'd0, ifa.no_signal}, 32'd1);
    chk("to_busy", {31'd0, ifa.busy}, 32'd0);
    chk("to_novalid", a_n, 32'd4);

    // Restart: no_signal clears on the arming rise, first valid after 4 periods.
    run(2, 1'b1);
    chk("rs_pre_arm", {31'd0, ifa.no_signal}, 32'd1);
    run(1, 1'b1);
    chk("rs_armed", {31'd0, ifa.no_signal}, 32'd0);
    run(47, 1'b1);
    run(51, 1'b0);
    wave(101); wave(101); wave(102);
    chk("rs_wait", a_n, 32'd4);
    wave(100);
    chk("rs_count", a_n, 32'd5);
    chk("rs_trunc", a_log[4], 32'd101);
    chk("rs_port", ifa.period_avg, 32'd101);

    // Enable dropped mid-window: window discarded, result held.
    wave(100); wave(100);
    en = 1'b0;
    run(10, 1'b0);
    chk("en_nosig", {31'd0, ifa.no_signal}, 32'd1);
    chk("en_busy", {31'd0, ifa.busy}, 32'd0);
    chk("en_hold", ifa.period_avg, 32'd101);
    chk("en_novalid", a_n, 32'd5);
    en = 1'b1;
    repeat (4) wave(100);
    chk("en_wait", a_n, 32'd5);
    wave(100);
    chk("en_count", a_n, 32'd6);
    chk("en_avg", a_log[5], 32'd100);

    // Asynchronous reset between clock edges while measuring.
    wave(100); wave(100);
    run(20, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_avg", ifa.period_avg, 32'd0);
    chk("ar_valid", {31'd0, ifa.period_valid}, 32'd0);
    chk("ar_nosig", {31'd0, ifa.no_signal}, 32'd1);
    chk("ar_busy", {31'd0, ifa.busy}, 32'd0);
    run(5, 1'b0);
    rst_n = 1'b1;
    repeat (3) wave(100);
    chk("ar_nospur", a_n, 32'd6);
    chk("ar_avg_after", ifa.period_avg, 32'd0);

    // Loopback from a phase-accumulator divider, increment 0x0100_0000.
    en = 1'b0;
    run(2, 1'b0);
    en = 1'b1;
    repeat (2560) begin
      acc = acc + 32'h0100_0000;
      sig = acc[31];
      tick();
    end
    chk("lb_count", a_n, 32'd8);
    chk("lb_avg0", a_log[6], 32'd256);
    chk("lb_avg1", a_log[7], 32'd256);
    chk("lb_space", a_cyc[7] - a_cyc[6], 32'd1024);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
